mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side end of the 2-bit command / 4-bit tag bus used by icache and dcache.
//  Accepts BUS_LOAD/BUS_STORE, returns a nonzero tag in the same cycle, and returns load data with that tag after a fixed latency.
//  Synthesizable 64-bit-word memory used under the processor top in sim and FPGA builds.
// PARAMETERS
//  MEM_WORDS    8192  number of 64-bit words (64 KiB); index = proc2mem_addr[3+:$clog2(MEM_WORDS)]
//  MEM_LATENCY  4     cycles from load acceptance to mem2proc_tag; legal range 1..14
//  NUM_TAGS     15    tag values 1..NUM_TAGS; 0 = no response / no completion
// PORTS
//  clock              in   1   clock; all state on posedge
//  reset              in   1   asynchronous, active-low (0 = reset)
//  proc2mem_command   in   2   BUS_NONE / BUS_LOAD / BUS_STORE
//  proc2mem_addr      in   32  byte address; [2:0] ignored
//  proc2mem_data      in   64  store data
//  init_we            in   1   backdoor image-load write enable
//  init_addr          in   32  backdoor word address (byte addr, [2:0] ignored)
//  init_data          in   64  backdoor data
//  mem2proc_response  out  4   tag of accepted request, same cycle; 0 = refused
//  mem2proc_data      out  64  load data, valid when mem2proc_tag != 0, else 0
//  mem2proc_tag       out  4   completing load tag; 0 = none this cycle
// BEHAVIOUR
//  Reset (async assert): mem2proc_tag = 0, mem2proc_data = 0, mem2proc_response forced 0, pipeline cleared, next_tag = 1.
//   Memory array is not cleared.
//  Reset mid-operation: in-flight loads are dropped and their tags never complete. Stores accepted before reset persist.
//  Accept = command != BUS_NONE && addr index < MEM_WORDS && !init_we && !stall (see CONFIGURATION).
//  mem2proc_response = accept ? next_tag : 0. Combinational from inputs and next_tag; requester samples it in the issue cycle.
//  next_tag advances on every accept: 1,2,..,NUM_TAGS,1 (0 skipped). Because MEM_LATENCY < NUM_TAGS, tags never alias.
//  BUS_STORE accepted: mem[idx] <= proc2mem_data at that edge. Tag consumed, no completion ever returned.
//  BUS_LOAD accepted: mem[idx] read in the accept cycle; {tag,data} enters stage 0 of a MEM_LATENCY-deep delay line.
//   At the exit edge, mem2proc_tag/mem2proc_data are registered. Visible exactly MEM_LATENCY cycles after the accept edge, for one cycle.
//  Load then store to same word in later cycle: load returns old data (read-at-accept).
//  Store then load, back-to-back cycles: load returns new data (write-first on the array port).
//  One request per cycle max. Completions are in order, at most one per cycle; back-to-back loads give back-to-back completions.
//  Refused requests (response 0) have no side effect; requester must retry.
//  init_we: mem[init idx] <= init_data. Command in the same cycle is refused.
//  Out-of-range index: refused, no write.
// CONFIGURATION
//  MEM_RESP_STALL_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) steps every cycle.
//   stall = lfsr[0] & lfsr[3], which refuses about 25% of otherwise-acceptable requests to exercise requester retry.
//  MEM_RESP_STALL_EN undefined: stall = 0, no LFSR logic.
// STRUCTURE
//  sys_defs package: BUS_COMMAND enum (BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2).
//   Also MEM_RESP_PKT typedef {logic valid; logic [3:0] tag; logic [63:0] data}, and MEM_TAG_NONE = 4'd0.
//  Sub-module mem_resp_pipe: parameterized MEM_LATENCY-stage MEM_RESP_PKT shift register with async active-low clear.
//  Top holds the array, tag counter, accept logic and optional LFSR.
// TESTING
//  Reset released, no commands -> response=0, tag=0, data=0 for 20 cycles.
//  init word 0x100 = 64'hDEAD_BEEF_0123_4567; LOAD 0x100 at cycle T -> response=1 at T.
//   At T+4: tag=1, data=64'hDEAD_BEEF_0123_4567. At T+5: tag=0.
//  16 back-to-back LOADs -> responses 1..15 then 1; tags 1..15,1 complete on 16 consecutive cycles, in order.
//  STORE 0x200 = 64'h1111 at T, LOAD 0x200 at T+1 -> store response 1 with no completion.
//   Load response 2, and at T+5 tag=2, data=64'h1111.
//  LOAD to index >= MEM_WORDS, or with init_we=1 -> response=0, no completion within 10 cycles.
//  Reset pulsed 2 cycles after LOAD accepted -> tag stays 0. Next LOAD gets response=1. Memory contents intact.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Bus command encoding and response packet shared by the caches and the memory responder.
package sys_defs;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    localparam logic [3:0] MEM_TAG_NONE = 4'd0;

    typedef struct packed {
        logic        valid;
        logic [3:0]  tag;
        logic [63:0] data;
    } MEM_RESP_PKT;

    // Tags run 1..num_tags and wrap back to 1; 0 is reserved for "no tag".
    function automatic logic [3:0] next_tag_f(input logic [3:0] tag, input int num_tags);
        return (int'(tag) >= num_tags) ? 4'd1 : tag + 4'd1;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Command/tag bus between a cache (master) and the memory responder (slave).
interface mem_responder_if;
    import sys_defs::*;

    BUS_COMMAND  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );

endinterface

// File: rtl/mem_responder_pipe.sv
// Fixed-latency delay line for load responses; async clear drops anything in flight.
module mem_resp_pipe
    import sys_defs::*;
#(
    parameter int STAGES = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  MEM_RESP_PKT pkt_i,
    output MEM_RESP_PKT pkt_o
);

    MEM_RESP_PKT [STAGES-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = pkt_i;
        for (int i = 1; i < STAGES; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) pipe_q <= '0;
        else          pipe_q <= pipe_d;
    end

    assign pkt_o = pipe_q[STAGES-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: tags each accepted request, returns load data after MEM_LATENCY cycles.
// Define MEM_RESP_STALL_EN to add an LFSR that randomly refuses requests to exercise retry.
module mem_responder
    import sys_defs::*;
#(
    parameter int MEM_WORDS   = 8192,
    parameter int MEM_LATENCY = 4,
    parameter int NUM_TAGS    = 15
) (
    input  logic            clock,
    input  logic            reset,
    mem_responder_if.slave  bus,
    input  logic            init_we,
    input  logic [31:0]     init_addr,
    input  logic [63:0]     init_data
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [63:0]      mem [MEM_WORDS];
    logic [3:0]       next_tag_q, next_tag_d;
    logic             bus_in_range, init_in_range;
    logic             stall, accept, load_acc, store_acc;
    logic [IDX_W-1:0] bus_idx, init_idx, wr_idx;
    logic             wr_en;
    logic [63:0]      wr_data;
    MEM_RESP_PKT      pkt_in, pkt_out;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{bus.proc2mem_addr[2:0], init_addr[2:0]};

    // Range is judged on the full word address so high bits never alias into the array.
    assign bus_in_range  = (bus.proc2mem_addr[31:3] < 29'(MEM_WORDS));
    assign init_in_range = (init_addr[31:3] < 29'(MEM_WORDS));
    assign bus_idx       = bus.proc2mem_addr[3 +: IDX_W];
    assign init_idx      = init_addr[3 +: IDX_W];

`ifdef MEM_RESP_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // x^8+x^6+x^5+x^4+1, Fibonacci form
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) lfsr_q <= 8'hA5;
        else        lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0] & lfsr_q[3];
`else
    assign stall = 1'b0;
`endif

    assign accept    = reset && (bus.proc2mem_command != BUS_NONE) && bus_in_range
                       && !init_we && !stall;
    assign load_acc  = accept && (bus.proc2mem_command == BUS_LOAD);
    assign store_acc = accept && (bus.proc2mem_command == BUS_STORE);

    assign bus.mem2proc_response = accept ? next_tag_q : MEM_TAG_NONE;

    always_comb begin
        next_tag_d = next_tag_q;
        if (accept) next_tag_d = next_tag_f(next_tag_q, NUM_TAGS);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) next_tag_q <= 4'd1;
        else        next_tag_q <= next_tag_d;
    end

    // Single write port: backdoor init wins, and any bus command that cycle is refused.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = bus_idx;
        wr_data = bus.proc2mem_data;
        if (init_we && init_in_range) begin
            wr_en   = 1'b1;
            wr_idx  = init_idx;
            wr_data = init_data;
        end else if (store_acc) begin
            wr_en = 1'b1;
        end
    end

    // Array holds its contents through reset.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    // Read happens at accept, so a later store to the same word does not affect this load.
    always_comb begin
        pkt_in = '0;
        if (load_acc) begin
            pkt_in.valid = 1'b1;
            pkt_in.tag   = next_tag_q;
            pkt_in.data  = mem[bus_idx];
        end
    end

    mem_resp_pipe #(.STAGES(MEM_LATENCY)) u_pipe (
        .clk_i   (clock),
        .rst_n_i (reset),
        .pkt_i   (pkt_in),
        .pkt_o   (pkt_out)
    );

    assign bus.mem2proc_tag  = pkt_out.valid ? pkt_out.tag  : MEM_TAG_NONE;
    assign bus.mem2proc_data = pkt_out.valid ? pkt_out.data : 64'd0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic against a word/tag reference model.
`timescale 1ns/1ps
module tb_mem_responder;
    import sys_defs::*;

    localparam int LAT   = 4;
    localparam int NT    = 15;
    localparam int WORDS = 8192;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_we;
    logic [31:0] init_addr;
    logic [63:0] init_data;

    mem_responder_if bus ();

    mem_responder #(.MEM_WORDS(WORDS), .MEM_LATENCY(LAT), .NUM_TAGS(NT)) dut (
        .clock     (clock),
        .reset     (rst_n),
        .bus       (bus),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Reference model: word contents, next tag, and expected completion per cycle.
    logic [63:0] ref_mem  [int];
    logic [3:0]  ref_tag;
    logic [3:0]  exp_tag  [int];
    logic [63:0] exp_data [int];
    logic [3:0]  mon_et;
    logic [63:0] mon_ed;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic model_cycle(input BUS_COMMAND cmd, input logic [31:0] addr, input logic [63:0] wd,
                               input logic iwe, input logic [31:0] ia, input logic [63:0] idat,
                               output logic [3:0] resp);
        int widx = int'(addr >> 3);
        int iidx = int'(ia >> 3);
        resp = 4'd0;
        if (rst_n && cmd != BUS_NONE && widx < WORDS && !iwe) begin
            resp = ref_tag;
            if (cmd == BUS_LOAD) begin
                exp_tag[cyc + LAT]  = ref_tag;
                exp_data[cyc + LAT] = ref_mem[widx];
            end else begin
                ref_mem[widx] = wd;
            end
            ref_tag = (ref_tag == 4'(NT)) ? 4'd1 : ref_tag + 4'd1;
        end
        if (iwe && iidx < WORDS) ref_mem[iidx] = idat;
    endtask

    task automatic issue(input BUS_COMMAND cmd, input logic [31:0] addr, input logic [63:0] wd,
                         input logic iwe, input logic [31:0] ia, input logic [63:0] idat,
                         output logic [3:0] resp, output logic [3:0] exp);
        @(posedge clock); #1;
        bus.proc2mem_command = cmd;
        bus.proc2mem_addr    = addr;
        bus.proc2mem_data    = wd;
        init_we   = iwe;
        init_addr = ia;
        init_data = idat;
        @(negedge clock);
        resp = bus.mem2proc_response;
        model_cycle(cmd, addr, wd, iwe, ia, idat, exp);
    endtask

    task automatic idle(input int n);
        logic [3:0] r, e;
        repeat (n) issue(BUS_NONE, 32'd0, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        bus.proc2mem_command = BUS_NONE;
        init_we = 1'b0;
        rst_n   = 1'b0;
        exp_tag.delete();
        exp_data.delete();
        ref_tag = 4'd1;
        @(posedge clock); #1;
        rst_n = 1'b1;
    endtask

    // Completion scoreboard: every cycle the tag/data must match what the model scheduled.
    always @(negedge clock) begin
        if (chk_en) begin
            mon_et = exp_tag.exists(cyc)  ? exp_tag[cyc]  : 4'd0;
            mon_ed = exp_data.exists(cyc) ? exp_data[cyc] : 64'd0;
            n_cmp++;
            if (bus.mem2proc_tag !== mon_et) begin
                n_err++;
                $display("FAIL completion_tag cyc=%0d got %0d want %0d", cyc, bus.mem2proc_tag, mon_et);
            end
            n_cmp++;
            if (bus.mem2proc_data !== mon_ed) begin
                n_err++;
                $display("FAIL completion_data cyc=%0d got %h want %h", cyc, bus.mem2proc_data, mon_ed);
            end
            exp_tag.delete(cyc);
            exp_data.delete(cyc);
        end
    end

    task automatic test_reset();
        logic [3:0] r, e;
        bus.proc2mem_command = BUS_LOAD;
        bus.proc2mem_addr    = 32'h100;
        bus.proc2mem_data    = 64'd0;
        init_we   = 1'b0;
        init_addr = 32'd0;
        init_data = 64'd0;
        ref_tag   = 4'd1;
        repeat (2) begin
            @(negedge clock);
            n_cmp++;
            if (bus.mem2proc_response !== 4'd0) begin n_err++; $display("FAIL reset_response got %0d want 0", bus.mem2proc_response); end
            n_cmp++;
            if (bus.mem2proc_tag !== 4'd0) begin n_err++; $display("FAIL reset_tag got %0d want 0", bus.mem2proc_tag); end
            n_cmp++;
            if (bus.mem2proc_data !== 64'd0) begin n_err++; $display("FAIL reset_data got %h want 0", bus.mem2proc_data); end
        end
        @(posedge clock); #1;
        bus.proc2mem_command = BUS_NONE;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            issue(BUS_NONE, 32'd0, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
            n_cmp++;
            if (r !== 4'd0 || bus.mem2proc_tag !== 4'd0 || bus.mem2proc_data !== 64'd0) begin
                n_err++;
                $display("FAIL idle_outputs cyc=%0d got resp=%0d tag=%0d data=%h want all 0", cyc, r, bus.mem2proc_tag, bus.mem2proc_data);
            end
        end
    endtask

    task automatic test_single_load();
        logic [3:0] r, e;
        issue(BUS_NONE, 32'd0, 64'd0, 1'b1, 32'h100, 64'hDEAD_BEEF_0123_4567, r, e);
        issue(BUS_LOAD, 32'h100, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
        n_cmp++;
        if (r !== 4'd1) begin n_err++; $display("FAIL single_load_response got %0d want 1", r); end
        idle(4);
        n_cmp++;
        if (bus.mem2proc_tag !== 4'd1 || bus.mem2proc_data !== 64'hDEAD_BEEF_0123_4567) begin
            n_err++;
            $display("FAIL single_load_completion got tag=%0d data=%h want tag=1 data=deadbeef01234567", bus.mem2proc_tag, bus.mem2proc_data);
        end
        idle(1);
        n_cmp++;
        if (bus.mem2proc_tag !== 4'd0) begin n_err++; $display("FAIL single_load_one_cycle got tag=%0d want 0", bus.mem2proc_tag); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] r, e;
        int t0;
        int oc[$];
        logic [3:0] ot[$];
        pulse_reset();
        for (int k = 0; k < 16; k++)
            issue(BUS_NONE, 32'd0, 64'd0, 1'b1, 32'h2000 + 32'(8 * k), {$urandom, $urandom}, r, e);
        t0 = 0;
        for (int i = 0; i < 16; i++) begin
            issue(BUS_LOAD, 32'h2000 + 32'(8 * i), 64'd0, 1'b0, 32'd0, 64'd0, r, e);
            if (i == 0) t0 = cyc;
            n_cmp++;
            if (r !== 4'((i % NT) + 1)) begin n_err++; $display("FAIL b2b_response i=%0d got %0d want %0d", i, r, (i % NT) + 1); end
            if (bus.mem2proc_tag !== 4'd0) begin oc.push_back(cyc); ot.push_back(bus.mem2proc_tag); end
        end
        for (int i = 0; i < 10; i++) begin
            issue(BUS_NONE, 32'd0, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
            if (bus.mem2proc_tag !== 4'd0) begin oc.push_back(cyc); ot.push_back(bus.mem2proc_tag); end
        end
        n_cmp++;
        if (oc.size() != 16) begin n_err++; $display("FAIL b2b_completion_count got %0d want 16", oc.size()); end
        for (int i = 0; i < oc.size() && i < 16; i++) begin
            n_cmp++;
            if (ot[i] !== 4'((i % NT) + 1) || oc[i] != t0 + LAT + i) begin
                n_err++;
                $display("FAIL b2b_completion i=%0d got tag=%0d cyc=%0d want tag=%0d cyc=%0d", i, ot[i], oc[i], (i % NT) + 1, t0 + LAT + i);
            end
        end
    endtask

    task automatic test_store_load();
        logic [3:0] r, e;
        pulse_reset();
        issue(BUS_STORE, 32'h200, 64'h1111, 1'b0, 32'd0, 64'd0, r, e);
        n_cmp++;
        if (r !== 4'd1) begin n_err++; $display("FAIL store_response got %0d want 1", r); end
        issue(BUS_LOAD, 32'h200, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
        n_cmp++;
        if (r !== 4'd2) begin n_err++; $display("FAIL store_load_response got %0d want 2", r); end
        idle(3);
        n_cmp++;
        if (bus.mem2proc_tag !== 4'd0) begin n_err++; $display("FAIL store_no_completion got tag=%0d want 0", bus.mem2proc_tag); end
        idle(1);
        n_cmp++;
        if (bus.mem2proc_tag !== 4'd2 || bus.mem2proc_data !== 64'h1111) begin
            n_err++;
            $display("FAIL store_then_load got tag=%0d data=%h want tag=2 data=1111", bus.mem2proc_tag, bus.mem2proc_data);
        end
        // load-then-store: the load must see the older value
        issue(BUS_NONE, 32'd0, 64'd0, 1'b1, 32'h300, 64'hAAAA_0000_5555_0001, r, e);
        issue(BUS_LOAD, 32'h300, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
        issue(BUS_STORE, 32'h300, 64'hBBBB_0000_6666_0002, 1'b0, 32'd0, 64'd0, r, e);
        idle(3);
        n_cmp++;
        if (bus.mem2proc_data !== 64'hAAAA_0000_5555_0001) begin n_err++; $display("FAIL load_then_store got %h want aaaa000055550001", bus.mem2proc_data); end
        issue(BUS_LOAD, 32'h300, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
        idle(4);
        n_cmp++;
        if (bus.mem2proc_data !== 64'hBBBB_0000_6666_0002) begin n_err++; $display("FAIL store_persist got %h want bbbb000066660002", bus.mem2proc_data); end
    endtask

    task automatic test_refused();
        logic [3:0] r, e;
        issue(BUS_LOAD, 32'h0001_0000, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
        n_cmp++;
        if (r !== 4'd0) begin n_err++; $display("FAIL oob_load_response got %0d want 0", r); end
        issue(BUS_LOAD, 32'h100, 64'd0, 1'b1, 32'h500, 64'hC0FF_EE00_1234_5678, r, e);
        n_cmp++;
        if (r !== 4'd0) begin n_err++; $display("FAIL init_we_load_response got %0d want 0", r); end
        issue(BUS_STORE, 32'h0001_0100, 64'hBAD, 1'b0, 32'd0, 64'd0, r, e);
        n_cmp++;
        if (r !== 4'd0) begin n_err++; $display("FAIL oob_store_response got %0d want 0", r); end
        for (int i = 0; i < 10; i++) begin
            issue(BUS_NONE, 32'd0, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
            n_cmp++;
            if (bus.mem2proc_tag !== 4'd0) begin n_err++; $display("FAIL refused_no_completion i=%0d got tag=%0d want 0", i, bus.mem2proc_tag); end
        end
        issue(BUS_LOAD, 32'h100, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
        issue(BUS_LOAD, 32'h500, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
        idle(3);
        n_cmp++;
        if (bus.mem2proc_data !== 64'hDEAD_BEEF_0123_4567) begin n_err++; $display("FAIL oob_store_no_write got %h want deadbeef01234567", bus.mem2proc_data); end
        idle(1);
        n_cmp++;
        if (bus.mem2proc_data !== 64'hC0FF_EE00_1234_5678) begin n_err++; $display("FAIL init_write got %h want c0ffee0012345678", bus.mem2proc_data); end
    endtask

    task automatic test_random();
        logic [3:0] r, e;
        BUS_COMMAND cmd;
        logic [31:0] a, ia;
        logic iwe;
        int sel;
        for (int k = 0; k < 8; k++)
            issue(BUS_NONE, 32'd0, 64'd0, 1'b1, 32'h3000 + 32'(8 * k), {$urandom, $urandom}, r, e);
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            a   = 32'h3000 + 32'(8 * $urandom_range(0, 7)) + 32'($urandom_range(0, 7));
            ia  = 32'h3000 + 32'(8 * $urandom_range(0, 7));
            iwe = 1'b0;
            cmd = BUS_NONE;
            if (sel >= 2 && sel <= 5) cmd = BUS_LOAD;
            else if (sel == 6 || sel == 7) cmd = BUS_STORE;
            else if (sel == 8) begin
                cmd = ($urandom_range(0, 1) == 0) ? BUS_LOAD : BUS_STORE;
                a   = $urandom | 32'h0001_0000;
            end else if (sel == 9) begin
                cmd = ($urandom_range(0, 1) == 0) ? BUS_LOAD : BUS_STORE;
                iwe = 1'b1;
            end
            issue(cmd, a, {$urandom, $urandom}, iwe, ia, {$urandom, $urandom}, r, e);
            n_cmp++;
            if (r !== e) begin n_err++; $display("FAIL random_response n=%0d got %0d want %0d", n, r, e); end
        end
        idle(LAT + 2);
    endtask

    task automatic test_reset_midflight();
        logic [3:0] r, e;
        issue(BUS_LOAD, 32'h100, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
        idle(2);
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            issue(BUS_NONE, 32'd0, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
            n_cmp++;
            if (bus.mem2proc_tag !== 4'd0) begin n_err++; $display("FAIL midflight_dropped i=%0d got tag=%0d want 0", i, bus.mem2proc_tag); end
        end
        issue(BUS_LOAD, 32'h100, 64'd0, 1'b0, 32'd0, 64'd0, r, e);
        n_cmp++;
        if (r !== 4'd1) begin n_err++; $display("FAIL post_reset_response got %0d want 1", r); end
        idle(4);
        n_cmp++;
        if (bus.mem2proc_tag !== 4'd1 || bus.mem2proc_data !== 64'hDEAD_BEEF_0123_4567) begin
            n_err++;
            $display("FAIL post_reset_memory got tag=%0d data=%h want tag=1 data=deadbeef01234567", bus.mem2proc_tag, bus.mem2proc_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_back_to_back();
        test_store_load();
        test_refused();
        test_random();
        test_reset_midflight();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
